ahb_mtx_arb_rr_burst: RTL and testbench



---
 rtl/ahb_mtx_arb_rr_burst_pkg.sv | 43 ++++
 rtl/ahb_mtx_arb_rr_burst_pick.sv | 35 +++
 rtl/ahb_mtx_arb_rr_burst.sv | 172 +++++++++++++++++
 tb/tb_ahb_mtx_arb_rr_burst.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_mtx_arb_rr_burst_pkg.sv
// ============================================================================
// Package     : ahb_mtx_arb_pkg
// Description : AHB transfer/burst codes and burst-length helper shared by the
//               matrix output-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_mtx_arb_pkg;

    localparam int BEAT_W = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // Remaining beats after the NONSEQ of a burst; zero for SINGLE and INCR.
    function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd7;
            HBURST_WRAP16, HBURST_INCR16: return 5'd15;
            default:                      return 5'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_mtx_arb_rr_burst_pick.sv
// ============================================================================
// Module      : ahb_mtx_rr_pick
// Description : Combinational rotating-priority picker; the first requester at
//               or after i_ptr (modulo NUM_PORTS) wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_mtx_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_any
);

    // Offsets are walked from farthest to nearest so the nearest requester
    // is the last assignment and therefore wins.
    always_comb begin
        o_idx = '0;
        o_any = |i_req;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (i_req[i] && (i_ptr == IDX_W'((i + NUM_PORTS - k) % NUM_PORTS))) begin
                    o_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ahb_mtx_arb_rr_burst.sv
// ============================================================================
// Module      : ahb_mtx_arb_rr_burst
// Description : Round-robin output-stage arbiter for one AHB matrix slave port,
//               holding the grant across locked sequences and bursts.
//               Optional macro AHBMTX_ARB_MAX_HOLD_EN caps INCR burst hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_mtx_arb_rr_burst
    import ahb_mtx_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 3,
    parameter int MAX_HOLD  = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [IDX_W-1:0]     addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);

    generate
        if ((2 ** IDX_W < NUM_PORTS) || (NUM_PORTS < 2) || (MAX_HOLD < 1)) begin : g_bad_cfg
            $error("ahb_mtx_arb_rr_burst: illegal parameter combination");
        end
    endgenerate

    logic [IDX_W-1:0]  r_addr;
    logic              r_no_port;
    logic              r_burst_hold;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [BEAT_W-1:0] r_beat_cnt;

    logic              w_is_idle;
    logic              w_is_busy;
    logic              w_is_nonseq;
    logic              w_is_seq;
    logic              w_is_incr;
    logic              w_acc;
    logic [BEAT_W-1:0] w_len;
    logic              w_fixed;
    logic              w_hold_fixed;
    logic              w_incr_term;
    logic              w_hold_incr;
    logic              w_hold;
    logic [IDX_W-1:0]  w_pick;
    logic              w_any_req;
    logic              w_regrant;
    logic [IDX_W-1:0]  w_ptr_nxt;

    assign w_is_idle   = (HTRANSM == HTRANS_IDLE);
    assign w_is_busy   = (HTRANSM == HTRANS_BUSY);
    assign w_is_nonseq = (HTRANSM == HTRANS_NONSEQ);
    assign w_is_seq    = (HTRANSM == HTRANS_SEQ);
    assign w_is_incr   = (HBURSTM == HBURST_INCR);
    assign w_acc       = HREADYM & HSELM & HTRANSM[1];
    assign w_len       = burst_beats(HBURSTM);
    assign w_fixed     = (w_len != '0);

    // Fixed bursts hold until the final beat is accepted; BUSY in the middle
    // of a fixed burst must not let the grant slip.
    assign w_hold_fixed = (w_acc & w_is_nonseq & w_fixed)
                        | (w_acc & w_is_seq & (r_beat_cnt > 5'd1))
                        | (HSELM & w_is_busy & w_fixed);

    assign w_incr_term = HSELM & w_is_incr & (w_is_busy | w_is_seq);

    assign w_hold    = HMASTLOCKM | w_hold_fixed | w_hold_incr;
    assign w_regrant = ~w_hold & w_any_req;
    assign w_ptr_nxt = (w_pick == IDX_W'(NUM_PORTS - 1)) ? '0 : w_pick + IDX_W'(1);

    ahb_mtx_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .i_req (req_port),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick),
        .o_any (w_any_req)
    );

`ifdef AHBMTX_ARB_MAX_HOLD_EN
    localparam int c_HCNT_W = $clog2(MAX_HOLD) + 1;

    logic [c_HCNT_W-1:0] r_hold_cnt;
    logic                w_other_req;
    logic                w_cap_hit;

    always_comb begin
        w_other_req = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_port[i] && (r_addr != IDX_W'(i))) begin
                w_other_req = 1'b1;
            end
        end
    end

    // Once the INCR burst has used its beat budget, a waiting port forces
    // rearbitration; a locked sequence still keeps the grant.
    assign w_cap_hit   = (r_hold_cnt >= c_HCNT_W'(MAX_HOLD)) & w_other_req;
    assign w_hold_incr = w_incr_term & ~w_cap_hit;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hold_cnt <= '0;
        end else if (HREADYM) begin
            if (w_is_idle || (w_acc && w_is_nonseq) || w_regrant) begin
                r_hold_cnt <= '0;
            end else if (w_acc && w_is_seq && w_is_incr
                         && (r_hold_cnt < c_HCNT_W'(MAX_HOLD))) begin
                r_hold_cnt <= r_hold_cnt + c_HCNT_W'(1);
            end
        end
    end
`else
    assign w_hold_incr = w_incr_term;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_beat_cnt <= '0;
        end else if (HREADYM) begin
            if (w_acc && w_is_nonseq) begin
                r_beat_cnt <= w_len;
            end else if (w_acc && w_is_seq && (r_beat_cnt != '0)) begin
                r_beat_cnt <= r_beat_cnt - 5'd1;
            end else if (w_is_idle) begin
                r_beat_cnt <= '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr       <= '0;
            r_no_port    <= 1'b1;
            r_burst_hold <= 1'b0;
            r_rr_ptr     <= '0;
        end else if (HREADYM) begin
            if (w_hold) begin
                r_no_port    <= 1'b0;
                r_burst_hold <= 1'b1;
            end else begin
                r_burst_hold <= 1'b0;
                if (w_any_req) begin
                    r_addr    <= w_pick;
                    r_no_port <= 1'b0;
                    r_rr_ptr  <= w_ptr_nxt;
                end else if (HSELM) begin
                    r_no_port <= 1'b0;
                end else begin
                    r_no_port <= 1'b1;
                end
            end
        end
    end

    assign addr_in_port = r_addr;
    assign no_port      = r_no_port;
    assign burst_hold   = r_burst_hold;

endmodule

`default_nettype wire

// File: tb/tb_ahb_mtx_arb_rr_burst.sv
// ============================================================================
// Module      : tb_ahb_mtx_arb_rr_burst
// Description : Directed self-checking bench for the output-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ahb_mtx_arb_rr_burst;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_INCR8  = 3'b101;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] req_port;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic [2:0] addr_in_port;
    logic       no_port;
    logic       burst_hold;

    int n_cmp;
    int n_err;

    ahb_mtx_arb_rr_burst #(
        .NUM_PORTS (4),
        .IDX_W     (3),
        .MAX_HOLD  (4)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .burst_hold   (burst_hold)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic sel, input logic [1:0] tr,
                         input logic [2:0] bu, input logic lock, input logic rdy);
        req_port   = req;
        HSELM      = sel;
        HTRANSM    = tr;
        HBURSTM    = bu;
        HMASTLOCKM = lock;
        HREADYM    = rdy;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        drive(4'b0000, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (no_port !== 1'b1) begin
            n_err++; $display("FAIL reset_no_port got=%b exp=1", no_port);
        end
        n_cmp++;
        if (addr_in_port !== 3'd0) begin
            n_err++; $display("FAIL reset_addr got=%0d exp=0", addr_in_port);
        end
        n_cmp++;
        if (burst_hold !== 1'b0) begin
            n_err++; $display("FAIL reset_burst_hold got=%b exp=0", burst_hold);
        end
        HRESETn = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        drive(4'b1111, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_g = 3'(i % 4);
            n_cmp++;
            if (addr_in_port !== exp_g || no_port !== 1'b0 || burst_hold !== 1'b0) begin
                n_err++;
                $display("FAIL rr_grant step=%0d got addr=%0d np=%b bh=%b exp addr=%0d np=0 bh=0",
                         i, addr_in_port, no_port, burst_hold, exp_g);
            end
        end
    endtask

    task automatic test_incr4();
        drive(4'b1111, 1'b1, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd1) begin
            n_err++; $display("FAIL incr4_setup got=%0d exp=1", addr_in_port);
        end
        drive(4'b1111, 1'b1, T_NONSEQ, B_INCR4, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd1 || burst_hold !== 1'b1) begin
            n_err++; $display("FAIL incr4_nonseq got addr=%0d bh=%b exp addr=1 bh=1", addr_in_port, burst_hold);
        end
        drive(4'b1111, 1'b1, T_SEQ, B_INCR4, 1'b0, 1'b1);
        for (int j = 0; j < 2; j++) begin
            tick();
            n_cmp++;
            if (addr_in_port !== 3'd1 || burst_hold !== 1'b1) begin
                n_err++; $display("FAIL incr4_seq%0d got addr=%0d bh=%b exp addr=1 bh=1", j + 1, addr_in_port, burst_hold);
            end
        end
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd2 || burst_hold !== 1'b0) begin
            n_err++; $display("FAIL incr4_release got addr=%0d bh=%b exp addr=2 bh=0", addr_in_port, burst_hold);
        end
    endtask

    task automatic test_incr8_stall();
        drive(4'b1111, 1'b1, T_NONSEQ, B_INCR8, 1'b0, 1'b1);
        tick();
        drive(4'b1111, 1'b1, T_SEQ, B_INCR8, 1'b0, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd2 || burst_hold !== 1'b1) begin
            n_err++; $display("FAIL incr8_pre_stall got addr=%0d bh=%b exp addr=2 bh=1", addr_in_port, burst_hold);
        end
        drive(4'b1011, 1'b1, T_SEQ, B_INCR8, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            tick();
            n_cmp++;
            if (addr_in_port !== 3'd2 || burst_hold !== 1'b1 || no_port !== 1'b0) begin
                n_err++; $display("FAIL incr8_stall%0d got addr=%0d bh=%b np=%b exp addr=2 bh=1 np=0",
                                  j, addr_in_port, burst_hold, no_port);
            end
        end
        drive(4'b1111, 1'b1, T_SEQ, B_INCR8, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            tick();
            n_cmp++;
            if (addr_in_port !== 3'd2 || burst_hold !== 1'b1) begin
                n_err++; $display("FAIL incr8_beat%0d got addr=%0d bh=%b exp addr=2 bh=1", j + 4, addr_in_port, burst_hold);
            end
        end
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd3 || burst_hold !== 1'b0) begin
            n_err++; $display("FAIL incr8_release got addr=%0d bh=%b exp addr=3 bh=0", addr_in_port, burst_hold);
        end
    endtask

    task automatic test_lock();
        drive(4'b1111, 1'b1, T_NONSEQ, B_SINGLE, 1'b1, 1'b1);
        for (int j = 0; j < 6; j++) begin
            tick();
            n_cmp++;
            if (addr_in_port !== 3'd3 || burst_hold !== 1'b1) begin
                n_err++; $display("FAIL lock_hold%0d got addr=%0d bh=%b exp addr=3 bh=1", j, addr_in_port, burst_hold);
            end
        end
        drive(4'b1111, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd0 || burst_hold !== 1'b0) begin
            n_err++; $display("FAIL lock_release got addr=%0d bh=%b exp addr=0 bh=0", addr_in_port, burst_hold);
        end
    endtask

    task automatic test_no_request();
        drive(4'b0000, 1'b1, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd0 || no_port !== 1'b0) begin
            n_err++; $display("FAIL noreq_sel got addr=%0d np=%b exp addr=0 np=0", addr_in_port, no_port);
        end
        drive(4'b0000, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd0 || no_port !== 1'b1) begin
            n_err++; $display("FAIL noreq_idle got addr=%0d np=%b exp addr=0 np=1", addr_in_port, no_port);
        end
        drive(4'b0100, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd2 || no_port !== 1'b0) begin
            n_err++; $display("FAIL noreq_single got addr=%0d np=%b exp addr=2 np=0", addr_in_port, no_port);
        end
    endtask

    task automatic test_incr_max_hold();
        logic [2:0] exp_a;
        logic       exp_b;
        drive(4'b0001, 1'b1, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        tick();
        drive(4'b0001, 1'b1, T_NONSEQ, B_INCR, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd0 || burst_hold !== 1'b0) begin
            n_err++; $display("FAIL incr_start got addr=%0d bh=%b exp addr=0 bh=0", addr_in_port, burst_hold);
        end
        drive(4'b0101, 1'b1, T_SEQ, B_INCR, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            tick();
`ifdef AHBMTX_ARB_MAX_HOLD_EN
            exp_a = (k <= 4) ? 3'd0 : 3'd2;
            exp_b = (k != 5);
`else
            exp_a = 3'd0;
            exp_b = 1'b1;
`endif
            n_cmp++;
            if (addr_in_port !== exp_a || burst_hold !== exp_b) begin
                n_err++; $display("FAIL incr_beat%0d got addr=%0d bh=%b exp addr=%0d bh=%b",
                                  k + 1, addr_in_port, burst_hold, exp_a, exp_b);
            end
        end
        drive(4'b0101, 1'b1, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        tick();
`ifdef AHBMTX_ARB_MAX_HOLD_EN
        exp_a = 3'd0;
`else
        exp_a = 3'd2;
`endif
        n_cmp++;
        if (addr_in_port !== exp_a || burst_hold !== 1'b0) begin
            n_err++; $display("FAIL incr_end got addr=%0d bh=%b exp addr=%0d bh=0", addr_in_port, burst_hold, exp_a);
        end
    endtask

    task automatic test_reset_mid_burst();
        drive(4'b1111, 1'b1, T_NONSEQ, B_INCR4, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (burst_hold !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre got bh=%b exp bh=1", burst_hold);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        n_cmp++;
        if (addr_in_port !== 3'd0 || no_port !== 1'b1 || burst_hold !== 1'b0) begin
            n_err++; $display("FAIL rstmid_async got addr=%0d np=%b bh=%b exp addr=0 np=1 bh=0",
                              addr_in_port, no_port, burst_hold);
        end
        #1;
        HRESETn = 1'b1;
        drive(4'b0010, 1'b1, T_SEQ, B_INCR4, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (addr_in_port !== 3'd1 || burst_hold !== 1'b0 || no_port !== 1'b0) begin
            n_err++; $display("FAIL rstmid_no_residual got addr=%0d bh=%b np=%b exp addr=1 bh=0 np=0",
                              addr_in_port, burst_hold, no_port);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_round_robin();
        test_incr4();
        test_incr8_stall();
        test_lock();
        test_no_request();
        test_incr_max_hold();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
